// File: rtl/alu_seq_ctrl.sv
// Multi-cycle control unit for the 8-bit ALU datapath: fetches 16-bit
// instructions over req/ack and sequences them through FETCH/DECODE/EXEC/WB.
module alu_seq_ctrl #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [3:0] HALT_OP  = 4'b1111
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ack,
  output logic [1:0]  rf_raddr1,
  output logic [1:0]  rf_raddr2,
  output logic        rf_we,
  output logic [1:0]  rf_waddr,
  output logic [3:0]  alu_opcode,
  output logic        alu_b_imm,
  output logic [7:0]  imm,
  output logic [4:0]  shamt,
  output logic        dir,
  input  logic        alu_branch_taken,
  output logic [7:0]  pc,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  pc_q, pc_d;
  logic        req_q, req_d;
  logic        taken_q, taken_d;
  logic        halted_q, halted_d;
  logic [1:0]  raddr1_q, raddr1_d;
  logic [1:0]  raddr2_q, raddr2_d;
  logic        we_q, we_d;
  logic [1:0]  waddr_q, waddr_d;
  logic [3:0]  opcode_q, opcode_d;
  logic        b_imm_q, b_imm_d;

  logic [3:0]  op;
  logic [3:0]  fetch_op;
  logic        op_writes;
  logic        op_branch;

  assign op        = ir_q[15:12];
  assign fetch_op  = imem_rdata[15:12];
  assign op_writes = (op <= 4'b0110) || (op == 4'b1001);
  assign op_branch = (op == 4'b1011) || (op == 4'b1100);

  // Registered outputs are computed from the next state, so each control is
  // already valid during the cycle of the state that owns it.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pc_d     = pc_q;
    req_d    = req_q;
    taken_d  = taken_q;
    halted_d = halted_q;
    raddr1_d = raddr1_q;
    raddr2_d = raddr2_q;
    we_d     = we_q;
    waddr_d  = waddr_q;
    opcode_d = opcode_q;
    b_imm_d  = b_imm_q;
    case (state_q)
      S_FETCH: begin
        if (req_q && imem_ack) begin
          ir_d     = imem_rdata;
          req_d    = 1'b0;
          raddr1_d = imem_rdata[9:8];
          raddr2_d = (fetch_op <= 4'b0101) ? imem_rdata[7:6] : imem_rdata[11:10];
          state_d  = S_DECODE;
        end else begin
          req_d = 1'b1;
        end
      end
      S_DECODE: begin
        opcode_d = op;
        b_imm_d  = (op == 4'b1001);
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        taken_d = op_branch && alu_branch_taken;
        if (op == HALT_OP) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          we_d    = op_writes;
          waddr_d = ir_q[11:10];
          state_d = S_WB;
        end
      end
      S_WB: begin
        we_d    = 1'b0;
        pc_d    = taken_q ? (pc_q + 8'd1 + ir_q[7:0]) : (pc_q + 8'd1);
        req_d   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        req_d = 1'b0;
        we_d  = 1'b0;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      ir_q     <= '0;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      taken_q  <= 1'b0;
      halted_q <= 1'b0;
      raddr1_q <= '0;
      raddr2_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      opcode_q <= '0;
      b_imm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      taken_q  <= taken_d;
      halted_q <= halted_d;
      raddr1_q <= raddr1_d;
      raddr2_q <= raddr2_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      opcode_q <= opcode_d;
      b_imm_q  <= b_imm_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign halted     = halted_q;
  assign rf_raddr1  = raddr1_q;
  assign rf_raddr2  = raddr2_q;
  assign rf_we      = we_q;
  assign rf_waddr   = waddr_q;
  assign alu_opcode = opcode_q;
  assign alu_b_imm  = b_imm_q;
  assign imm        = ir_q[7:0];
  assign shamt      = ir_q[4:0];
  assign dir        = ir_q[5];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: a per-instruction expectation is queued
// when the instruction is fetched and compared after it retires.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic [1:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic        rf_we;
  logic [3:0]  alu_opcode;
  logic        alu_b_imm;
  logic [7:0]  imm;
  logic [4:0]  shamt;
  logic        dir;
  logic        alu_branch_taken = 1'b0;
  logic [7:0]  pc;
  logic        halted;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  logic [7:0] model_pc;

  typedef struct packed {
    logic [1:0] raddr1;
    logic [1:0] raddr2;
    logic [7:0] imm;
    logic [4:0] shamt;
    logic       dir;
    logic       we_pre;
    logic [3:0] opcode;
    logic       b_imm;
    logic       we;
    logic [1:0] waddr;
    logic [1:0] wb_raddr1;
    logic [1:0] wb_raddr2;
    logic [7:0] pc;
    logic       we_after;
    logic       halted;
  } obs_t;

  obs_t exp_q[$];

  alu_seq_ctrl #(.RESET_PC(8'h10), .HALT_OP(4'b1111)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_we(rf_we), .rf_waddr(rf_waddr),
    .alu_opcode(alu_opcode), .alu_b_imm(alu_b_imm),
    .imm(imm), .shamt(shamt), .dir(dir),
    .alu_branch_taken(alu_branch_taken),
    .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic obs_t model(input logic [15:0] ir, input logic [7:0] pc0, input bit tk);
    obs_t e;
    logic [3:0] op;
    op = ir[15:12];
    e.raddr1    = ir[9:8];
    e.raddr2    = (op < 4'd6) ? ir[7:6] : ir[11:10];
    e.imm       = ir[7:0];
    e.shamt     = ir[4:0];
    e.dir       = ir[5];
    e.we_pre    = 1'b0;
    e.opcode    = op;
    e.b_imm     = (op == 4'd9);
    e.we        = (op != 4'hF) && ((op < 4'd7) || (op == 4'd9));
    e.waddr     = e.we ? ir[11:10] : 2'b00;
    e.wb_raddr1 = e.raddr1;
    e.wb_raddr2 = e.raddr2;
    if (op == 4'hF)
      e.pc = pc0;
    else if ((op == 4'd11 || op == 4'd12) && tk)
      e.pc = pc0 + 8'd1 + ir[7:0];
    else
      e.pc = pc0 + 8'd1;
    e.we_after  = 1'b0;
    e.halted    = (op == 4'hF);
    return e;
  endfunction

  // Acts as instruction memory (ack in the lat-th cycle of req) and samples the
  // DUT once in each of DECODE, EXEC, WB and the following state.
  task automatic do_instr(input logic [15:0] ir, input int lat, input bit tk,
                          output int reqc, output logic [7:0] addr, output obs_t o);
    int n;
    n = 0;
    o = '0;
    reqc = 0;
    addr = '0;
    while (imem_req !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (imem_req !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL fetch_timeout got imem_req=%b required=1 within 40 cycles", imem_req);
      return;
    end
    addr = imem_addr;
    for (int i = 1; i <= lat; i++) begin
      if (imem_req === 1'b1) reqc++;
      if (i == lat) begin
        imem_ack   = 1'b1;
        imem_rdata = ir;
      end
      @(posedge clk); #1;
      imem_ack   = 1'b0;
      imem_rdata = 16'($urandom);
    end
    o.raddr1 = rf_raddr1;
    o.raddr2 = rf_raddr2;
    o.imm    = imm;
    o.shamt  = shamt;
    o.dir    = dir;
    alu_branch_taken = tk;
    @(posedge clk); #1;
    o.opcode = alu_opcode;
    o.b_imm  = alu_b_imm;
    o.we_pre = rf_we;
    @(posedge clk); #1;
    alu_branch_taken = 1'b0;
    o.we        = rf_we;
    o.waddr     = rf_we ? rf_waddr : 2'b00;
    o.wb_raddr1 = rf_raddr1;
    o.wb_raddr2 = rf_raddr2;
    @(posedge clk); #1;
    o.pc       = pc;
    o.we_after = rf_we;
    o.halted   = halted;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b required=0", imem_req); end
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b required=0", rf_we); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b required=0", halted); end
    checks++; if (pc !== 8'h10) begin failures++; $display("FAIL reset_pc got=%h required=10", pc); end
    checks++; if (alu_opcode !== 4'h0 || alu_b_imm !== 1'b0) begin
      failures++; $display("FAIL reset_alu got=%h/%b required=0/0", alu_opcode, alu_b_imm); end
    checks++; if (imm !== 8'h00) begin failures++; $display("FAIL reset_ir got=%h required=00", imm); end
    // ack presented while imem_req is still low must be ignored
    rst = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 16'h9105;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h10) begin
      failures++; $display("FAIL release_fetch got req=%b addr=%h required req=1 addr=10", imem_req, imem_addr); end
    checks++; if (halted !== 1'b0 || rf_we !== 1'b0 || imm !== 8'h00) begin
      failures++; $display("FAIL stray_ack got halted=%b we=%b imm=%h required 0/0/00", halted, rf_we, imm); end
    model_pc = 8'h10;
  endtask

  task automatic test_add();
    obs_t o, e;
    int reqc;
    logic [7:0] addr;
    int unsigned c0;
    c0 = cyc;
    exp_q.push_back(model(16'h06C0, model_pc, 1'b0));
    do_instr(16'h06C0, 1, 1'b0, reqc, addr, o);
    e = exp_q.pop_front();
    checks++; if (o !== e) begin failures++; $display("FAIL add_obs got=%h required=%h", o, e); end
    checks++; if (addr !== 8'h10 || reqc != 1) begin
      failures++; $display("FAIL add_fetch got addr=%h reqc=%0d required 10/1", addr, reqc); end
    checks++; if (o.pc !== 8'h11 || o.raddr1 !== 2'd2 || o.raddr2 !== 2'd3 || o.waddr !== 2'd1) begin
      failures++; $display("FAIL add_fields got pc=%h r1=%0d r2=%0d wa=%0d required 11/2/3/1", o.pc, o.raddr1, o.raddr2, o.waddr); end
    checks++; if (imem_req !== 1'b1 || (cyc - c0) != 4) begin
      failures++; $display("FAIL add_cpi got req=%b cycles=%0d required 1/4", imem_req, cyc - c0); end
    model_pc = e.pc;
  endtask

  task automatic test_addi();
    obs_t o, e;
    int reqc;
    logic [7:0] addr;
    exp_q.push_back(model(16'h9105, model_pc, 1'b0));
    do_instr(16'h9105, 3, 1'b0, reqc, addr, o);
    e = exp_q.pop_front();
    checks++; if (o !== e) begin failures++; $display("FAIL addi_obs got=%h required=%h", o, e); end
    checks++; if (reqc != 3 || addr !== 8'h11) begin
      failures++; $display("FAIL addi_req_hold got reqc=%0d addr=%h required 3/11", reqc, addr); end
    checks++; if (o.b_imm !== 1'b1 || o.imm !== 8'h05 || o.we !== 1'b1 || o.waddr !== 2'd0) begin
      failures++; $display("FAIL addi_fields got bimm=%b imm=%h we=%b wa=%0d required 1/05/1/0", o.b_imm, o.imm, o.we, o.waddr); end
    model_pc = e.pc;
  endtask

  task automatic test_branch();
    logic [15:0] irs [6] = '{16'hB00D, 16'hB6FE, 16'hB000, 16'hB6FE, 16'hC4DD, 16'h7000};
    bit          tks [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0]  pcs [6] = '{8'h20, 8'h1F, 8'h20, 8'h21, 8'hFF, 8'h00};
    obs_t o, e;
    int reqc;
    logic [7:0] addr, pc0;
    for (int i = 0; i < 6; i++) begin
      pc0 = model_pc;
      exp_q.push_back(model(irs[i], model_pc, tks[i]));
      do_instr(irs[i], 1, tks[i], reqc, addr, o);
      e = exp_q.pop_front();
      checks++; if (o !== e || addr !== pc0) begin
        failures++; $display("FAIL branch[%0d] got=%h addr=%h required=%h addr=%h", i, o, addr, e, pc0); end
      checks++; if (o.pc !== pcs[i] || o.we !== 1'b0) begin
        failures++; $display("FAIL branch_pc[%0d] got pc=%h we=%b required pc=%h we=0", i, o.pc, o.we, pcs[i]); end
      model_pc = e.pc;
    end
  endtask

  task automatic test_shift();
    obs_t o, e;
    int reqc;
    logic [7:0] addr;
    exp_q.push_back(model(16'h6523, model_pc, 1'b0));
    do_instr(16'h6523, 2, 1'b0, reqc, addr, o);
    e = exp_q.pop_front();
    checks++; if (o !== e) begin failures++; $display("FAIL shift_obs got=%h required=%h", o, e); end
    checks++; if (o.dir !== 1'b1 || o.shamt !== 5'd3 || o.opcode !== 4'b0110 || o.waddr !== 2'd1 || o.we !== 1'b1) begin
      failures++; $display("FAIL shift_fields got dir=%b sh=%0d op=%h wa=%0d we=%b required 1/3/6/1/1",
                           o.dir, o.shamt, o.opcode, o.waddr, o.we); end
    model_pc = e.pc;
    exp_q.push_back(model(16'h7A40, model_pc, 1'b1));
    do_instr(16'h7A40, 1, 1'b1, reqc, addr, o);
    e = exp_q.pop_front();
    checks++; if (o !== e || o.we !== 1'b0 || o.pc !== 8'h02) begin
      failures++; $display("FAIL nop_obs got=%h required=%h", o, e); end
    model_pc = e.pc;
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    int reqc, lat;
    logic [7:0] addr, pc0;
    logic [15:0] ir;
    bit tk;
    for (int i = 0; i < 10; i++) begin
      ir  = {4'($urandom_range(0, 14)), 12'($urandom)};
      lat = $urandom_range(1, 3);
      tk  = 1'($urandom_range(0, 1));
      pc0 = model_pc;
      exp_q.push_back(model(ir, model_pc, tk));
      do_instr(ir, lat, tk, reqc, addr, o);
      e = exp_q.pop_front();
      checks++; if (o !== e || addr !== pc0 || reqc != lat) begin
        failures++; $display("FAIL b2b[%0d] ir=%h got=%h addr=%h reqc=%0d required=%h addr=%h reqc=%0d",
                             i, ir, o, addr, reqc, e, pc0, lat); end
      model_pc = e.pc;
    end
  endtask

  task automatic test_halt();
    obs_t o, e;
    int reqc;
    logic [7:0] addr;
    bit bad;
    exp_q.push_back(model(16'hF000, model_pc, 1'b0));
    do_instr(16'hF000, 1, 1'b0, reqc, addr, o);
    e = exp_q.pop_front();
    checks++; if (o !== e || o.halted !== 1'b1) begin failures++; $display("FAIL halt_obs got=%h required=%h", o, e); end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = 16'h06C0;
      @(posedge clk); #1;
      if (imem_req !== 1'b0 || pc !== model_pc || halted !== 1'b1 || rf_we !== 1'b0) bad = 1'b1;
    end
    imem_ack = 1'b0;
    checks++; if (bad) begin
      failures++; $display("FAIL halt_hold got req=%b pc=%h halted=%b we=%b required 0/%h/1/0", imem_req, pc, halted, rf_we, model_pc); end
  endtask

  task automatic test_reset_mid_fetch();
    obs_t o, e;
    int reqc;
    logic [7:0] addr;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    model_pc = 8'h10;
    exp_q.push_back(model(16'h06C0, model_pc, 1'b0));
    do_instr(16'h06C0, 2, 1'b0, reqc, addr, o);
    e = exp_q.pop_front();
    checks++; if (o !== e) begin failures++; $display("FAIL restart_obs got=%h required=%h", o, e); end
    model_pc = e.pc;
    @(posedge clk); #1;
    rst = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 16'h9105;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    checks++; if (imem_req !== 1'b0 || pc !== 8'h10 || imm !== 8'h00 || rf_we !== 1'b0 || halted !== 1'b0) begin
      failures++; $display("FAIL midfetch_reset got req=%b pc=%h imm=%h we=%b halted=%b required 0/10/00/0/0",
                           imem_req, pc, imm, rf_we, halted); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h10) begin
      failures++; $display("FAIL midfetch_refetch got req=%b addr=%h required 1/10", imem_req, imem_addr); end
    model_pc = 8'h10;
    exp_q.push_back(model(16'h9105, model_pc, 1'b0));
    do_instr(16'h9105, 1, 1'b0, reqc, addr, o);
    e = exp_q.pop_front();
    checks++; if (o !== e || addr !== 8'h10) begin failures++; $display("FAIL midfetch_after got=%h required=%h", o, e); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_addi();
    test_branch();
    test_shift();
    test_back_to_back();
    test_halt();
    test_reset_mid_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle control unit for the 8-bit ALU datapath.
- Fetches 16-bit instructions over a req/ack port and drives the register file read/write controls, ALU opcode, immediate select, shift controls and PC.
- Sits between instruction memory, the 4-entry register file and the ALU.
- Sequences one instruction through FETCH -> DECODE -> EXEC -> WB.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset
HALT_OP, 4'b1111, opcode that stops the sequencer

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  instruction fetch request
imem_addr  output  8  fetch address (= pc)
imem_rdata  input  16  instruction word, valid when imem_ack=1
imem_ack  input  1  fetch completion, single-cycle pulse
rf_raddr1  output  2  register file read port 1 address
rf_raddr2  output  2  register file read port 2 address
rf_we  output  1  register file write enable
rf_waddr  output  2  register file write address
alu_opcode  output  4  ALU opcode
alu_b_imm  output  1  1 = ALU operand B is imm, 0 = register read port 2
imm  output  8  immediate, IR[7:0]
shamt  output  5  shift amount, IR[4:0]
dir  output  1  shift direction, IR[5]
alu_branch_taken  input  1  branch result from ALU
pc  output  8  program counter
halted  output  1  1 after HALT_OP has executed

Behaviour:
- Instruction format:
  - op = IR[15:12], rd = IR[11:10], rs = IR[9:8], rt = IR[7:6], imm = IR[7:0].
  - SHIFT uses dir = IR[5] and shamt = IR[4:0].
- Reset:
  - State = FETCH, pc = RESET_PC, IR = 0, halted = 0.
  - rf_we = 0, imem_req = 0, alu_opcode = 4'b0000, alu_b_imm = 0.
  - Reset wins over all other activity. Mid-fetch, imem_req drops the next cycle, and a concurrent ack is ignored.
- FETCH:
  - imem_req = 1 and imem_addr = pc, held until imem_ack.
  - On ack: IR <= imem_rdata, imem_req deasserts the next cycle, go to DECODE.
  - An ack arriving while imem_req = 0 is ignored.
- DECODE (1 cycle): rf_raddr1 = rs. rf_raddr2 = rt for R-type ops 0000..0101, else rd.
- EXEC (1 cycle):
  - alu_opcode = op.
  - alu_b_imm = 1 for op 1001 (ADDI) only.
  - BEQ/BNE (1011/1100) compare rs against rd: rf_raddr1 = rs, rf_raddr2 = rd.
  - alu_branch_taken is sampled at the end of EXEC.
- WB (1 cycle):
  - rf_we = 1 with rf_waddr = rd for ops 0000..0110 and 1001.
  - rf_we = 0 for branches, undefined opcodes (NOP) and HALT_OP.
  - PC update:
    - Branch taken: pc <= pc + 1 + sign_extend(imm).
    - Otherwise: pc <= pc + 1.
    - All PC arithmetic is modulo 256 (wraps 8'hFF -> 8'h00).
  - Then go to FETCH.
- HALT_OP:
  - Decodes to state HALT after EXEC: no write, pc unchanged, halted = 1.
  - No further fetch until rst.
- rf_raddr1/rf_raddr2 and the ALU controls hold their values from DECODE/EXEC through WB. They are don't-care in FETCH.
- Throughput and latency:
  - CPI = 3 + fetch latency.
  - Minimum 4 cycles per instruction when ack arrives the cycle after req.
- Outputs are registered except imem_addr (= pc) and imm/shamt/dir (direct IR slices).

Test Plan:
- Reset with RESET_PC=8'h10, then release -> imem_req=1, imem_addr=8'h10, halted=0, rf_we=0 on the first cycle.
- Fetch ADD r1,r2,r3 (16'h0_6_C0), ack 1 cycle after req -> rf_raddr1=2, rf_raddr2=3, alu_opcode=0000, alu_b_imm=0; rf_we=1 with rf_waddr=1 in WB; pc 8'h10->8'h11; next imem_req 4 cycles after the first.
- ADDI r0,r1,imm=8'h05 (16'h9_1_05), ack delayed 3 cycles -> imem_req held high 3 cycles; alu_b_imm=1, imm=8'h05; one rf_we pulse to r0.
- BEQ with pc=8'h20, imm=8'hFE, alu_branch_taken=1 -> pc=8'h1F, rf_we=0. Same with taken=0 -> pc=8'h21. pc=8'hFF non-branch -> pc=8'h00.
- SHIFT 16'h6_5_23 -> dir=1, shamt=5'd3, alu_opcode=0110, rf_waddr=1. Opcode 4'b0111 -> no rf_we, pc+1.
- HALT 16'hF000 -> halted=1, imem_req stays 0 for 20 cycles, pc frozen; assert rst mid-FETCH of another run -> state FETCH, pc=RESET_PC next cycle, stray ack ignored.
